// File: rtl/vov_vote_accumulator.sv
// Accumulates thermometer vote vectors over N_WIN windows per frame and
// presents the frame sum plus a threshold decision on a valid/ready output.
module vov_vote_accumulator #(
   parameter int K     = 4,
   parameter int N_WIN = 8,
   parameter int SUM_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             vov_valid,
   input  logic [K-1:0]     vov,
   input  logic [SUM_W-1:0] thresh,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [SUM_W-1:0] out_sum,
   output logic             out_vote,
   output logic             bubble_err,
   output logic             ovf_err
);

   localparam int CNT_W = $clog2(K + 1);
   localparam int WIN_W = (N_WIN > 1) ? $clog2(N_WIN) : 1;
   localparam logic [SUM_W-1:0] SUM_MAX = '1;

   typedef enum logic {IDLE, HOLD} state_t;

   state_t             state;
   logic [WIN_W-1:0]   win_cnt;
   logic               win_last;
   logic [CNT_W-1:0]   pop;
   logic               legal;
   logic               s1_valid;
   logic               s1_last;
   logic [CNT_W-1:0]   s1_cnt;
   logic [SUM_W-1:0]   acc;
   logic [SUM_W:0]     sum_ext;
   logic [SUM_W-1:0]   sum_sat;
   logic               final_valid;
   logic               xfer;

   // A legal vote has exactly its popcount of ones packed against the MSB.
   always_comb begin
      pop = '0;
      for (int i = 0; i < K; i++) begin
         pop = pop + CNT_W'(vov[i]);
      end
      legal = (vov == ~({K{1'b1}} >> pop));
   end

   assign win_last = (win_cnt == WIN_W'(N_WIN - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid   <= 1'b0;
         s1_last    <= 1'b0;
         s1_cnt     <= '0;
         win_cnt    <= '0;
         bubble_err <= 1'b0;
      end else if (clear) begin
         s1_valid   <= 1'b0;
         s1_last    <= 1'b0;
         s1_cnt     <= '0;
         win_cnt    <= '0;
         bubble_err <= 1'b0;
      end else begin
         s1_valid <= vov_valid;
         if (vov_valid) begin
            s1_cnt  <= pop;
            s1_last <= win_last;
            win_cnt <= win_last ? '0 : win_cnt + WIN_W'(1);
            if (!legal) begin
               bubble_err <= 1'b1;
            end
         end
      end
   end

   // Saturating add so a frame sum can never wrap to a small value.
   always_comb begin
      sum_ext = {1'b0, acc} + (SUM_W + 1)'(s1_cnt);
      sum_sat = sum_ext[SUM_W] ? SUM_MAX : sum_ext[SUM_W-1:0];
   end

   assign final_valid = s1_valid && s1_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (s1_valid) begin
         acc <= s1_last ? '0 : sum_sat;
      end
   end

   assign xfer = (state == HOLD) && out_ready;

   // A final arriving while an untransferred result is held is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_vote  <= 1'b0;
         ovf_err   <= 1'b0;
      end else if (clear) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_vote  <= 1'b0;
         ovf_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (final_valid) begin
                  state     <= HOLD;
                  out_valid <= 1'b1;
                  out_sum   <= sum_sat;
                  out_vote  <= (sum_sat >= thresh);
               end
            end
            HOLD: begin
               if (xfer) begin
                  if (final_valid) begin
                     out_sum  <= sum_sat;
                     out_vote <= (sum_sat >= thresh);
                  end else begin
                     state     <= IDLE;
                     out_valid <= 1'b0;
                  end
               end else if (final_valid) begin
                  ovf_err <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vov_vote_accumulator.sv
// Directed plus randomized bench for vov_vote_accumulator, checked against a
// frame-level reference model of the vote accumulator.
module tb_vov_vote_accumulator;

   localparam int K     = 4;
   localparam int N_WIN = 8;
   localparam int SUM_W = 6;
   localparam int SUM_MAX = (1 << SUM_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             clear = 1'b0;
   logic             vov_valid = 1'b0;
   logic [K-1:0]     vov = '0;
   logic [SUM_W-1:0] thresh = '0;
   logic             out_ready = 1'b0;
   logic             out_valid;
   logic [SUM_W-1:0] out_sum;
   logic             out_vote;
   logic             bubble_err;
   logic             ovf_err;

   int checks = 0;
   int errors = 0;

   // Reference model state: windows seen in the current frame, running frame
   // total, a finished frame waiting one cycle to reach the output, and the
   // result currently offered downstream.
   int m_win, m_frame_sum;
   bit m_sched_valid;
   int m_sched_sum;
   bit m_valid, m_vote, m_bubble, m_ovf;
   int m_sum;

   vov_vote_accumulator #(.K(K), .N_WIN(N_WIN), .SUM_W(SUM_W)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .vov_valid(vov_valid),
      .vov(vov), .thresh(thresh), .out_ready(out_ready), .out_valid(out_valid),
      .out_sum(out_sum), .out_vote(out_vote), .bubble_err(bubble_err),
      .ovf_err(ovf_err)
   );

   always #5 clk = ~clk;

   function automatic bit is_thermo(input int v);
      for (int n = 0; n <= K; n++) begin
         if (v == ((((1 << n) - 1) << (K - n)) & ((1 << K) - 1))) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic logic [K-1:0] thermo(input int n);
      int p;
      p = (((1 << n) - 1) << (K - n)) & ((1 << K) - 1);
      return K'(p);
   endfunction

   task automatic model_reset();
      m_win = 0; m_frame_sum = 0; m_sched_valid = 0; m_sched_sum = 0;
      m_valid = 0; m_sum = 0; m_vote = 0; m_bubble = 0; m_ovf = 0;
   endtask

   // One clock edge of the model, given the inputs seen at that edge.
   task automatic model_edge(input bit vv, input int v, input bit rdy, input bit clr, input int th);
      bit xfer;
      if (clr) begin
         model_reset();
         return;
      end
      xfer = m_valid && rdy;
      if (m_sched_valid) begin
         if (!m_valid || xfer) begin
            m_valid = 1; m_sum = m_sched_sum; m_vote = (m_sched_sum >= th);
         end else begin
            m_ovf = 1;
         end
      end else if (xfer) begin
         m_valid = 0;
      end
      m_sched_valid = 0;
      if (vv) begin
         if (!is_thermo(v)) m_bubble = 1;
         m_frame_sum += $countones(v);
         m_win++;
         if (m_win == N_WIN) begin
            m_sched_valid = 1;
            m_sched_sum = (m_frame_sum > SUM_MAX) ? SUM_MAX : m_frame_sum;
            m_win = 0;
            m_frame_sum = 0;
         end
      end
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string where);
      check_output({where, " out_valid"}, 32'(out_valid), 32'(m_valid));
      check_output({where, " out_sum"}, 32'(out_sum), 32'(m_sum));
      check_output({where, " out_vote"}, 32'(out_vote), 32'(m_vote));
      check_output({where, " bubble_err"}, 32'(bubble_err), 32'(m_bubble));
      check_output({where, " ovf_err"}, 32'(ovf_err), 32'(m_ovf));
   endtask

   task automatic apply_stimulus(input bit vv, input logic [K-1:0] v, input bit rdy, input bit clr);
      vov_valid = vv; vov = v; out_ready = rdy; clear = clr;
      @(posedge clk);
      model_edge(vv, int'(v), rdy, clr, int'(thresh));
      #1;
      check_all("cycle");
   endtask

   task automatic send_window(input logic [K-1:0] v, input bit rdy);
      apply_stimulus(1'b1, v, rdy, 1'b0);
      for (int i = 0; i < 3; i++) apply_stimulus(1'b0, '0, rdy, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      vov_valid = 0; clear = 0; out_ready = 0;
      rst_n = 0;
      model_reset();
      #1;
      check_output("reset out_valid", 32'(out_valid), 32'd0);
      check_output("reset out_sum", 32'(out_sum), 32'd0);
      check_output("reset out_vote", 32'(out_vote), 32'd0);
      check_output("reset bubble_err", 32'(bubble_err), 32'd0);
      check_output("reset ovf_err", 32'(ovf_err), 32'd0);
      @(negedge clk);
      rst_n = 1;
   endtask

   initial begin
      int gap;
      logic [K-1:0] v;
      model_reset();
      do_reset();

      // Basic frame with the result taken immediately.
      thresh = 16;
      for (int w = 0; w < 7; w++) send_window(4'b1100, 1'b1);
      apply_stimulus(1'b1, 4'b1100, 1'b1, 1'b0);
      apply_stimulus(1'b0, '0, 1'b1, 1'b0);
      check_output("t1 valid", 32'(out_valid), 32'd1);
      check_output("t1 sum", 32'(out_sum), 32'd16);
      check_output("t1 vote", 32'(out_vote), 32'd1);
      apply_stimulus(1'b0, '0, 1'b1, 1'b0);
      check_output("t1 drained", 32'(out_valid), 32'd0);
      apply_stimulus(1'b0, '0, 1'b1, 1'b0);

      // Threshold just above the sum, then a full-scale frame.
      thresh = 17;
      for (int w = 0; w < 8; w++) send_window((w % 2 == 0) ? 4'b1000 : 4'b1110, 1'b0);
      check_output("t2 sum", 32'(out_sum), 32'd16);
      check_output("t2 vote", 32'(out_vote), 32'd0);
      apply_stimulus(1'b0, '0, 1'b1, 1'b0);
      for (int w = 0; w < 8; w++) send_window(4'b1111, 1'b0);
      check_output("t2b sum", 32'(out_sum), 32'd32);
      check_output("t2b vote", 32'(out_vote), 32'd1);
      apply_stimulus(1'b0, '0, 1'b1, 1'b0);

      // Downstream stalled across two frames.
      thresh = 16;
      for (int w = 0; w < 8; w++) send_window(4'b1000, 1'b0);
      for (int w = 0; w < 8; w++) send_window(4'b1110, 1'b0);
      check_output("t3 held sum", 32'(out_sum), 32'd8);
      check_output("t3 ovf", 32'(ovf_err), 32'd1);
      apply_stimulus(1'b0, '0, 1'b1, 1'b0);
      check_output("t3 one transfer", 32'(out_valid), 32'd0);
      apply_stimulus(1'b0, '0, 1'b0, 1'b1);
      check_output("t3 clear ovf", 32'(ovf_err), 32'd0);

      // New final lands in the same cycle as the transfer.
      for (int w = 0; w < 8; w++) send_window(4'b1100, 1'b0);
      for (int w = 0; w < 7; w++) send_window(4'b1111, 1'b0);
      apply_stimulus(1'b1, 4'b1111, 1'b0, 1'b0);
      apply_stimulus(1'b0, '0, 1'b1, 1'b0);
      check_output("t4 valid", 32'(out_valid), 32'd1);
      check_output("t4 sum", 32'(out_sum), 32'd32);
      check_output("t4 ovf", 32'(ovf_err), 32'd0);
      apply_stimulus(1'b0, '0, 1'b1, 1'b0);

      // Bubble in window 3, then clear mid-frame.
      for (int w = 0; w < 8; w++) begin
         if (w == 3) begin
            apply_stimulus(1'b1, 4'b0101, 1'b0, 1'b0);
            check_output("t5 bubble", 32'(bubble_err), 32'd1);
            for (int i = 0; i < 3; i++) apply_stimulus(1'b0, '0, 1'b0, 1'b0);
         end else begin
            send_window(4'b1100, 1'b0);
         end
      end
      check_output("t5 sum", 32'(out_sum), 32'd16);
      for (int w = 0; w < 3; w++) send_window(4'b1111, 1'b0);
      apply_stimulus(1'b1, 4'b1111, 1'b0, 1'b1);
      check_output("t5 clear bubble", 32'(bubble_err), 32'd0);
      check_output("t5 clear valid", 32'(out_valid), 32'd0);
      for (int w = 0; w < 8; w++) send_window(4'b1000, 1'b0);
      check_output("t5 restart sum", 32'(out_sum), 32'd8);
      apply_stimulus(1'b0, '0, 1'b1, 1'b0);

      // Reset mid-frame discards the partial frame.
      for (int w = 0; w < 5; w++) send_window(4'b1111, 1'b1);
      do_reset();
      for (int w = 0; w < 8; w++) send_window(4'b1111, 1'b0);
      check_output("t6 sum", 32'(out_sum), 32'd32);
      apply_stimulus(1'b0, '0, 1'b1, 1'b0);

      // Randomized frames with random backpressure and thresholds.
      for (int f = 0; f < 8; f++) begin
         thresh = SUM_W'($urandom_range(0, SUM_MAX));
         for (int w = 0; w < N_WIN; w++) begin
            if ($urandom_range(0, 7) == 0) v = K'($urandom);
            else v = thermo($urandom_range(0, K));
            apply_stimulus(1'b1, v, 1'($urandom_range(0, 1)), 1'b0);
            gap = $urandom_range(3, 5);
            for (int i = 0; i < gap; i++) apply_stimulus(1'b0, '0, 1'($urandom_range(0, 1)), 1'b0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vov_vote_accumulator.md
Name: vov_vote_accumulator

Overview:
- Downstream consumer of the IPV reducer stage. It takes the k-bit thermometer vote vector (vov) once per reduction window, decodes it to a binary count, and accumulates counts over N_WIN windows to form one frame.
- At each frame end it emits the frame sum and a threshold decision on a valid/ready output.
- It holds one pending result while the next frame keeps accumulating.

Parameters:
- K, 4, width of vov; must match the upstream reducer's k (2..8).
- N_WIN, 8, windows per frame (2..255).
- SUM_W, 6, width of sum and threshold; must satisfy 2^SUM_W > K*N_WIN.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush: discards the partial frame and any pending output.
- vov_valid  input  1  vov is a window result this cycle (asserted at most 1 cycle in K).
- vov  input  K  thermometer vote, filled from MSB (e.g. K=4: 0000, 1000, 1100, 1110, 1111).
- thresh  input  SUM_W  decision threshold, sampled at frame completion.
- out_ready  input  1  downstream accepts the result.
- out_valid  output  1  result pending.
- out_sum  output  SUM_W  accumulated count of the frame.
- out_vote  output  1  1 when out_sum >= thresh (sampled value).
- bubble_err  output  1  sticky: a non-thermometer vov was received.
- ovf_err  output  1  sticky: a frame completed while the previous result was still pending.

Behaviour:
- Reset (rst_n low, async): every register is 0. out_valid=0, out_sum=0, out_vote=0, bubble_err=0, ovf_err=0, window counter=0, accumulator=0.
- Stage 1 (decode register): on vov_valid, register cnt = popcount(vov) and a last flag (window counter == N_WIN-1). Then increment the window counter, wrapping to 0 after N_WIN-1. When vov_valid=0, stage 1 is invalid.
- Bubble check: vov is legal iff it equals ~((1<<(K-n))-1) masked to K bits for some n in 0..K. An illegal vov sets bubble_err, which stays set until rst_n or clear. Its popcount is still accumulated.
- Stage 2 (accumulator):
  - Valid stage 1 and not last: acc <= acc + cnt.
  - Valid stage 1 and last: final = acc + cnt. Acc resets to 0 in the same cycle, and final goes to the output logic.
  - Sum saturates at 2^SUM_W-1; it must never wrap.
- Latency: vov_valid of the last window at cycle t gives out_valid=1 from cycle t+2.
- Output FSM has two states:
  - IDLE (out_valid=0): on final, load out_sum=final and out_vote=(final>=thresh), then go to HOLD.
  - HOLD (out_valid=1): the transfer happens on a cycle where out_valid and out_ready are both 1.
    - Transfer and no new final in the same cycle: go to IDLE.
    - Transfer and a new final in the same cycle: reload out_sum/out_vote from the new final and stay in HOLD (no bubble, no error).
    - No transfer and a new final: keep the old result, drop the new one, set ovf_err (sticky).
  - out_sum and out_vote must stay stable while out_valid=1 and out_ready=0.
- Accumulation continues in both states. vov_valid has no backpressure.
- clear (sync, highest priority):
  - Zeroes acc, the window counter, and stage 1.
  - Forces IDLE with out_valid=0, out_sum=0, out_vote=0.
  - Clears both sticky errors.
  - A vov_valid in the same cycle is discarded.
  - The next vov_valid starts window 0.
- Reset asserted mid-frame or while in HOLD: immediate return to reset values. The first vov_valid after release is window 0.
- out_vote is a single comparison on the registered final, with no glitch path from thresh after load.

Test Plan:
- K=4, N_WIN=8, thresh=16. Send 8 windows of vov=1100, one every 4 cycles, with out_ready=1 → out_valid pulses 2 cycles after the 8th vov_valid, out_sum=16, out_vote=1, no errors.
- Same setup with vov alternating 1000/1110 and thresh=17 → out_sum=16, out_vote=0. A second frame of all 1111 → out_sum=32, out_vote=1.
- Hold out_ready=0 across two full frames (first frame sum 8, second 24) → out_sum stays 8 and stable, ovf_err=1 at the second frame end. Raising out_ready gives one transfer of 8, then out_valid=0.
- With out_ready=1, make the new final land in the same cycle as the transfer → out_valid stays 1, out_sum updates to the new value, ovf_err stays 0.
- Inject vov=0101 in window 3 → bubble_err=1 from the next cycle and the frame sum includes 2. Then assert clear → bubble_err=0, out_valid=0, and the window counter restarts at 0.
- Assert rst_n low after 5 windows, then release and send 8 windows of 1111 → out_sum=32 (the partial frame is not carried over), and all outputs read 0 during reset.
